result_drain: RTL and testbench

- Reader-side counterpart of the CPU's result writer: after the RISC-V core signals completion, this block walks data memory and streams the result vector out over a valid/ready interface.
- It sits between the CPU data memory (second read port) and the result sink, which is a bench scoreboard in simulation or a host/UART bridge on hardware.
- Memory layout is fixed: word 0 holds rows, word 1 holds cols, results start at RES_BASE.

---
 rtl/result_drain_pkg.sv | 33 +++
 rtl/result_drain_if.sv | 36 +++
 rtl/result_drain.sv | 220 ++++++++++++++++++++++
 tb/tb_result_drain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// Shared constants and types for the result drain: FSM state encoding,
// header word locations in data memory and default geometry.
package result_drain_pkg;

  // Drain sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_RD   = 3'd1,
    HDR_WAIT = 3'd2,
    DAT_RD   = 3'd3,
    DAT_WAIT = 3'd4,
    PRESENT  = 3'd5,
    FIN      = 3'd6
  } drain_state_e;

  // Header layout written by the CPU program.
  localparam int unsigned HDR_ROWS_ADDR = 32'd0;
  localparam int unsigned HDR_COLS_ADDR = 32'd1;

  // Word address of result[0]; must match the CPU program/linker constant.
  localparam int unsigned RES_BASE_DEFAULT = 32'd512;

  // Default geometry of the data memory and result vector.
  localparam int unsigned ADDR_W_DEFAULT   = 32'd10;
  localparam int unsigned DATA_W_DEFAULT   = 32'd32;
  localparam int unsigned MAX_ROWS_DEFAULT = 32'd256;

  // Rising-edge detect of a level against its registered previous value.
  function automatic logic rising_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Bundles the data-memory read port and the result stream of the drain.
// master: the drain itself; slave: memory plus result sink.
interface result_drain_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index
  );

endinterface

// File: rtl/result_drain.sv
// Result drain: after the core signals completion, reads the row count from
// the header, then streams result[0..rows-1] out over valid/ready.
// All outputs come straight from flops.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int RES_BASE = RES_BASE_DEFAULT,
  parameter int MAX_ROWS = MAX_ROWS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  result_drain_if.master bus,
  output logic          busy,
  output logic          finished,
  output logic          hdr_err
);

  localparam logic [ADDR_W-1:0]        RES_BASE_A = ADDR_W'(RES_BASE);
  localparam logic [ADDR_W-1:0]        HDR_ADDR_A = ADDR_W'(HDR_ROWS_ADDR);
  localparam logic signed [DATA_W-1:0] MAX_ROWS_S = DATA_W'(MAX_ROWS);
  localparam logic [DATA_W-1:0]        ROW_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]        IDX_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  drain_state_e      state_q, state_d;
  logic              start_q;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic              hdr_err_q, hdr_err_d;
  logic [DATA_W-1:0] rows_q, rows_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic start_edge_s;
  logic hdr_nonpos_s;
  logic hdr_big_s;
  logic hs_s;
  logic last_s;

  // Only a fresh edge seen while idle starts a drain; a held level never retriggers.
  assign start_edge_s = rising_edge(start, start_q) && (state_q == IDLE);

  // Header row count is signed: zero or negative means an empty vector.
  assign hdr_nonpos_s = ($signed(bus.mem_rdata) <= $signed({DATA_W{1'b0}}));
  assign hdr_big_s    = ($signed(bus.mem_rdata) > MAX_ROWS_S);

  assign hs_s   = out_valid_q & bus.out_ready;
  assign last_s = (DATA_W'(idx_q) == (rows_q - ROW_ONE));

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign busy          = busy_q;
  assign finished      = finished_q;
  assign hdr_err       = hdr_err_q;

  // State, edge-detect, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_index_q <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      rows_q      <= {DATA_W{1'b0}};
      idx_q       <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      hdr_err_q   <= hdr_err_d;
      rows_q      <= rows_d;
      idx_q       <= idx_d;
    end
  end

  // Next-state decode of the drain sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          state_d = HDR_RD;
        end else begin
          state_d = IDLE;
        end
      end
      HDR_RD: begin
        state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (hdr_nonpos_s) begin
          state_d = FIN;
        end else begin
          state_d = DAT_RD;
        end
      end
      DAT_RD: begin
        state_d = DAT_WAIT;
      end
      DAT_WAIT: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (hs_s && last_s) begin
          state_d = FIN;
        end else if (hs_s) begin
          state_d = DAT_RD;
        end else begin
          state_d = PRESENT;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register inputs for the outputs, row count and element index.
  always_comb begin
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    busy_d      = busy_q;
    finished_d  = 1'b0;
    hdr_err_d   = hdr_err_q;
    rows_d      = rows_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (start_edge_s) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = HDR_ADDR_A;
          busy_d      = 1'b1;
          hdr_err_d   = 1'b0;
          rows_d      = {DATA_W{1'b0}};
          idx_d       = {ADDR_W{1'b0}};
        end else begin
          busy_d      = 1'b0;
        end
      end
      HDR_RD: begin
        mem_rd_en_d = 1'b0;
      end
      HDR_WAIT: begin
        if (hdr_nonpos_s) begin
          // Empty vector: skip straight to the completion pulse.
          hdr_err_d  = 1'b1;
          finished_d = 1'b1;
        end else if (hdr_big_s) begin
          // Oversized header: flag it but still drain the clamped length.
          hdr_err_d   = 1'b1;
          rows_d      = MAX_ROWS_S;
          idx_d       = {ADDR_W{1'b0}};
          mem_rd_en_d = 1'b1;
          mem_addr_d  = RES_BASE_A;
        end else begin
          rows_d      = bus.mem_rdata;
          idx_d       = {ADDR_W{1'b0}};
          mem_rd_en_d = 1'b1;
          mem_addr_d  = RES_BASE_A;
        end
      end
      DAT_RD: begin
        mem_rd_en_d = 1'b0;
      end
      DAT_WAIT: begin
        out_data_d  = bus.mem_rdata;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
      end
      PRESENT: begin
        if (hs_s && last_s) begin
          out_valid_d = 1'b0;
          finished_d  = 1'b1;
        end else if (hs_s) begin
          // Address wraps naturally at the memory size.
          out_valid_d = 1'b0;
          idx_d       = idx_q + IDX_ONE;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = RES_BASE_A + idx_q + IDX_ONE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      FIN: begin
        busy_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: memory model, scoreboard of expected
// (index, data) pairs, stall-stability monitor and read/pulse counters.
module tb_result_drain;

  typedef struct packed {
    logic [9:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, finished, hdr_err;

  result_drain_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  result_drain #(
    .ADDR_W(10), .DATA_W(32), .RES_BASE(512), .MAX_ROWS(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .finished(finished), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  exp_t        sb [$];
  int total = 0;
  int bad   = 0;
  int rd_cnt = 0, fin_cnt = 0, hs_cnt = 0;
  int rd0, fin0, hs0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [9:0]  hold_i;

  // Memory: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    else               bus.mem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: counts reads/pulses, checks handshakes against the scoreboard and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_data",  64'(bus.out_data),  64'(hold_d));
        chk("stall_index", 64'(bus.out_index), 64'(hold_i));
      end
      hold_v <= bus.out_valid && !bus.out_ready;
      hold_d <= bus.out_data;
      hold_i <= bus.out_index;
      if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (finished)      fin_cnt <= fin_cnt + 1;
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        hs_cnt <= hs_cnt + 1;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_index", 64'(bus.out_index), 64'(e.idx));
          chk("out_data",  64'(bus.out_data),  64'(e.data));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n);
    for (int k = 0; k < n; k++) sb.push_back('{idx: 10'(k), data: mem[512 + k]});
  endtask

  task automatic snap();
    rd0 = rd_cnt; fin0 = fin_cnt; hs0 = hs_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!bus.out_valid && n < budget) begin tick(); n++; end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic chk_counts(input string tag, input int rds, input int fins, input int hss);
    chk({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(rds));
    chk({tag, "_fin"},   64'(fin_cnt - fin0), 64'(fins));
    chk({tag, "_hs"},    64'(hs_cnt - hs0), 64'(hss));
    chk({tag, "_sb"},    64'(sb.size()), 64'd0);
  endtask

  task automatic load_small();
    mem[0]   = 32'd3;
    mem[1]   = 32'd1;
    mem[512] = 32'd10;
    mem[513] = 32'hFFFF_FFF9;
    mem[514] = 32'h7FFF_FFFF;
  endtask

  initial begin
    int lat;
    int stall;
    rst_n = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'(a * 3 + 1);
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    chk("rst_hdr_err", 64'(hdr_err), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);
    rst_n = 1'b1;
    tick();

    // T1: three signed elements, ready high, latency check
    load_small();
    push_exp(3);
    snap();
    bus.out_ready = 1'b1;
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_hdr_rd_en", 64'(bus.mem_rd_en), 64'd1);
    chk("t1_hdr_addr", 64'(bus.mem_addr), 64'd0);
    chk("t1_hdr_err", 64'(hdr_err), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    chk("t1_latency", 64'(lat), 64'd4);
    wait_idle(60, "t1");
    chk_counts("t1", 4, 1, 3);
    chk("t1_hdr_err_end", 64'(hdr_err), 64'd0);

    // T2: random stalls of 0..5 cycles
    push_exp(3);
    snap();
    bus.out_ready = 1'b0;
    stall = $urandom_range(0, 5);
    pulse_start();
    for (int c = 0; c < 200 && busy; c++) begin
      if (bus.out_valid) begin
        if (stall > 0) begin bus.out_ready = 1'b0; stall--; end
        else begin bus.out_ready = 1'b1; stall = $urandom_range(0, 5); end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    wait_idle(20, "t2");
    chk_counts("t2", 4, 1, 3);

    // T3: empty vectors (rows = 0, rows = -4)
    bus.out_ready = 1'b1;
    mem[0] = 32'd0;
    snap();
    pulse_start();
    wait_idle(20, "t3a");
    chk_counts("t3a", 1, 1, 0);
    chk("t3a_hdr_err", 64'(hdr_err), 64'd1);
    mem[0] = 32'hFFFF_FFFC;
    snap();
    pulse_start();
    wait_idle(20, "t3b");
    chk_counts("t3b", 1, 1, 0);
    chk("t3b_hdr_err", 64'(hdr_err), 64'd1);

    // T4: oversized header clamps to 256
    for (int k = 0; k < 300; k++) mem[512 + k] = 32'(k * 1000 - 50000);
    mem[0] = 32'd300;
    push_exp(256);
    snap();
    pulse_start();
    chk("t4_hdr_err_clear", 64'(hdr_err), 64'd0);
    wait_idle(1200, "t4");
    chk_counts("t4", 257, 1, 256);
    chk("t4_hdr_err", 64'(hdr_err), 64'd1);

    // T5: start held high, then an extra edge mid-drain
    load_small();
    push_exp(3);
    snap();
    start = 1'b1;
    repeat (50) tick();
    start = 1'b0;
    wait_idle(20, "t5a");
    chk_counts("t5a", 4, 1, 3);
    tick();
    push_exp(3);
    snap();
    pulse_start();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(60, "t5b");
    repeat (5) tick();
    chk_counts("t5b", 4, 1, 3);

    // T6: reset while presenting element 1, then a clean restart
    push_exp(3);
    snap();
    bus.out_ready = 1'b0;
    pulse_start();
    wait_valid(20, "t6_e0");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    wait_valid(20, "t6_e1");
    chk("t6_e1_index", 64'(bus.out_index), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("t6_rst_fin", 64'(fin_cnt - fin0), 64'd0);
    chk("t6_rst_sb_left", 64'(sb.size()), 64'd2);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle_fin", 64'(fin_cnt - fin0), 64'd0);
    push_exp(3);
    snap();
    bus.out_ready = 1'b1;
    pulse_start();
    wait_idle(60, "t6");
    chk_counts("t6", 4, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
